dmem_line_ctrl: RTL
===================

Name: dmem_line_ctrl

Overview:
- Line-granular data memory that sits directly downstream of the data cache and serves its 256-bit refill and write-back requests.
- Each request is latched on accept, held for a fixed programmable latency, then completed with a single-cycle ack.
- Reads return the full line. Writes commit the full line.
- A mandatory idle turnaround cycle follows each ack, so a requester that keeps enable asserted between back-to-back transactions (write-back then refill) is served correctly.

Parameters:
- LATENCY, 10: number of clock edges from request capture to the edge that raises ack_o. Must be >= 1.
- LINE_IDX_W, 9: line-index width; the array holds 2^LINE_IDX_W lines of 256 bits (default 16 KiB).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  request valid; level-sensitive, sampled only in IDLE.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  32  byte address; bits [4:0] ignored; line index = addr_i[LINE_IDX_W+4:5]; higher bits ignored (aliasing).
- data_i  in  256  write line data; sampled with enable_i.
- ack_o  out  1  completion pulse, exactly one cycle per transaction.
- data_o  out  256  read line data, valid while ack_o=1 for reads; holds its value until the next read completes.
- busy_o  out  1  high from the capture edge until the edge that returns to IDLE.

Behaviour:
- Reset (asynchronous, rst_i=0):
  - state=IDLE, cnt=0, ack_o=0, data_o=0, busy_o=0.
  - The latched request is discarded and no array write occurs.
  - Array contents are not reset; simulation initialises them to 0.
- States: IDLE, BUSY, DONE, TURN.
- IDLE:
  - At an edge with enable_i=1: latch idx, write_i and data_i; set cnt=1, busy_o=1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt >= LATENCY: go to DONE and set ack_o<=1.
    - Read: data_o <= array[idx_latched].
    - Write: array[idx_latched] <= data_latched; data_o is unchanged.
  - Else: cnt <= cnt+1.
- DONE (ack_o=1 for this cycle): at the next edge set ack_o<=0 and go to TURN.
- TURN: at the next edge go to IDLE and set busy_o<=0. Inputs are not sampled at this edge.
- Timing: if capture is at edge E0, ack_o is high for the single cycle following edge E0+LATENCY. The next capture can happen no earlier than edge E0+LATENCY+3.
- Inputs during a transaction: changes on enable_i, write_i, addr_i or data_i after capture are ignored. Dropping enable_i mid-transaction does not abort it.
- Read-after-write: a read of the same line issued after a write's ack returns the newly written data.
- cnt width is clog2(LATENCY+1). cnt saturates, and the compare uses >= so it can never wrap.
- Reset mid-BUSY: if rst_i falls before the DONE edge, the write does not commit and no ack is produced.
- Reset in DONE: ack_o drops immediately (asynchronously). A write already committed at the DONE edge stays committed.

Test Plan:
- Read, LATENCY=10: reset, then enable_i=1, write_i=0, addr_i=0x0000_0040 captured at edge 5 -> ack_o high only in the cycle after edge 15; data_o=0; busy_o falls after edge 17.
- Write then read: write line 0x0000_0040 with data_i=256'hA5..A5 and hold enable_i through the ack; deassert write_i in the ack cycle, keeping addr 0x40 -> the second request is captured at the first IDLE edge (edge+2 after ack), not in TURN; its ack returns data_o=A5..A5.
- Aliasing/offset: write addr 0x0000_401F with pattern P, then read 0x0000_0000 (LINE_IDX_W=9) -> data_o=P.
- Input changes ignored: start a write to line 3, then change addr_i to line 7 and data_i to Q during BUSY -> line 3 holds the original data and line 7 is unchanged (read back to confirm).
- Reset mid-operation: start a write to line 5, pulse rst_i low at cnt=4 -> no ack_o; a later read of line 5 returns the old contents; all outputs are 0 during reset.
- LATENCY=1 build: request captured at E0 -> ack_o is high in the cycle after E0+1; a second request with enable_i held high is captured at E0+4.

Source files
------------

// File: rtl/dmem_line_if.sv
// Request/completion bundle between the data cache and the line memory.
// Signal names keep the memory's _i/_o direction suffixes so both sides read the same.
interface dmem_line_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, busy_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, busy_o
  );
endinterface

// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory behind the data cache: latch a request, wait a fixed
// latency, then commit/return a full 256-bit line with a one-cycle ack and a turnaround cycle.
module dmem_line_ctrl #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned LINE_IDX_W = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_line_if.slave  bus
);

  localparam int unsigned      CNT_W   = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    TURN
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [LINE_IDX_W-1:0]   idx_q;
  logic [LINE_IDX_W-1:0]   idx_d;
  logic                    write_q;
  logic [255:0]            wdata_q;
  logic [255:0]            data_q;
  logic                    ack_q;
  logic                    busy_q;
  logic                    commit;
  logic                    unused_addr;

  logic [255:0] mem_q [2**LINE_IDX_W];

  // Byte offset and bits above the array size are dropped, so addresses alias.
  assign idx_d       = bus.addr_i[LINE_IDX_W+4:5];
  assign unused_addr = ^{bus.addr_i[31:LINE_IDX_W+5], bus.addr_i[4:0]};

  // cnt only advances below LATENCY, so >= makes it saturate instead of wrapping.
  assign commit = (state_q == BUSY) && (cnt_q >= CNT_MAX);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable_i) begin
            idx_q   <= idx_d;
            write_q <= bus.write_i;
            wdata_q <= bus.data_i;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (commit) begin
            ack_q   <= 1'b1;
            state_q <= DONE;
            if (!write_q) begin
              data_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          ack_q   <= 1'b0;
          state_q <= TURN;
        end
        TURN: begin
          // Inputs are deliberately ignored here so a held enable waits one more edge.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array is never reset; commit is already gated by the reset FSM state.
  always_ff @(posedge clk_i) begin
    if (commit && write_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = data_q;
  assign bus.busy_o = busy_q;

endmodule
